// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_N = 8;

endpackage

// File: rtl/mult_acc_shift.sv
// Accumulator for the shift-add multiplier: N+1-bit partial sum over N remaining multiplier bits.
// One add-and-shift per cycle when step is high; init loads the multiplier.
module mult_acc_shift import mult_pkg::*; #(
  parameter int N = MULT_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic [N-1:0]     mplier,
  input  logic [N-1:0]     mc,
  output logic [2*N-1:0]   acc_lo
);

  logic [2*N:0] acc_q;
  logic [2*N:0] acc_d;
  logic [N:0]   sum;

  // The add is N+1 bits wide so the carry lands in the top bit before the shift.
  assign sum = acc_q[2*N:N] + {1'b0, mc};

  always_comb begin
    acc_d = acc_q;
    if (init) begin
      acc_d = {{(N+1){1'b0}}, mplier};
    end else if (step) begin
      if (acc_q[0]) begin
        acc_d = {sum, acc_q[N-1:0]} >> 1;
      end else begin
        acc_d = acc_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_lo = acc_q[2*N-1:0];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned N x N multiplier; Done pulses N+2 cycles after St is accepted.
// Iteration count comes from an external counter via Load/K; St is ignored while busy.
module shift_add_mult import mult_pkg::*; #(
  parameter int N = MULT_N
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             St,
  input  logic [N-1:0]     Mplier,
  input  logic [N-1:0]     Mcand,
  input  logic             K,
  output logic             Load,
  output logic             Busy,
  output logic             Done,
  output logic [2*N-1:0]   Product
);

  mult_state_t     state_q, state_d;
  logic [N-1:0]    mc_q, mc_d;
  logic            load_q, load_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*N-1:0]  product_q, product_d;
  logic            acc_init;
  logic            acc_step;
  logic [2*N-1:0]  acc_prod;

  mult_acc_shift #(.N(N)) u_acc (
    .clk    (Clk),
    .rst    (rst),
    .init   (acc_init),
    .step   (acc_step),
    .mplier (Mplier),
    .mc     (mc_q),
    .acc_lo (acc_prod)
  );

  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    load_d    = load_q;
    busy_d    = busy_q;
    done_d    = done_q;
    product_d = product_q;
    acc_init  = 1'b0;
    acc_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (St) begin
          acc_init = 1'b1;
          mc_d     = Mcand;
          load_d   = 1'b1;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Load is a single-cycle pulse even if the counter reports K immediately.
        load_d = 1'b0;
        if (K) begin
          product_d = acc_prod;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          acc_step = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mc_q      <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign Load    = load_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult with a simple iteration-counter model driving K.
module tb_shift_add_mult;

  localparam int N = 8;

  logic           Clk = 1'b0;
  logic           rst;
  logic           St;
  logic [N-1:0]   Mplier;
  logic [N-1:0]   Mcand;
  logic           K = 1'b0;
  logic           Load;
  logic           Busy;
  logic           Done;
  logic [2*N-1:0] Product;

  shift_add_mult #(.N(N)) dut (
    .Clk     (Clk),
    .rst     (rst),
    .St      (St),
    .Mplier  (Mplier),
    .Mcand   (Mcand),
    .K       (K),
    .Load    (Load),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [2*N-1:0] exp_prod_q[$];
  int             exp_done_cyc_q[$];
  int             exp_load_cyc_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Counter model: K high in the (N+1)th RUN cycle counted from the Load pulse.
  int kcnt = 0;
  bit k_rand = 1'b0;
  always @(negedge Clk) begin
    if (rst)                          kcnt = 0;
    else if (Load)                    kcnt = 1;
    else if (kcnt != 0 && kcnt < N+2) kcnt++;
    else                              kcnt = 0;
    K = k_rand ? 1'($urandom_range(0, 1)) : (kcnt == N+1);
  end

  // Monitor: every Load and Done must match a scoreboard entry.
  always @(negedge Clk) begin
    if (Load) begin
      if (exp_load_cyc_q.size() == 0) check("unexpected_load", Load, 0);
      else                            check("load_cycle", cyc, exp_load_cyc_q.pop_front());
    end
    if (Done) begin
      if (exp_prod_q.size() == 0) begin
        check("unexpected_done", Done, 0);
      end else begin
        check("done_cycle", cyc, exp_done_cyc_q.pop_front());
        check("product", Product, exp_prod_q.pop_front());
      end
    end
  end

  // One operation; ign_cyc pulses St with other operands in that RUN cycle,
  // rst_cyc asserts reset in that RUN cycle and aborts the operation.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] p, input int ign_cyc, input int rst_cyc);
    int c0;
    @(negedge Clk);
    St = 1'b1; Mplier = a; Mcand = b;
    c0 = cyc + 1;
    exp_load_cyc_q.push_back(c0);
    if (rst_cyc == 0) begin
      exp_prod_q.push_back(p);
      exp_done_cyc_q.push_back(c0 + N + 1);
    end
    for (int c = 1; c <= N+3; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        St = 1'b0;
        check("busy_in_run", Busy, 1);
      end
      if (c == ign_cyc) begin
        St = 1'b1; Mplier = 8'd9; Mcand = 8'd9;
      end
      if (ign_cyc != 0 && c == ign_cyc + 1) St = 1'b0;
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        check("rst_load", Load, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_product", Product, 0);
      end
      if (rst_cyc != 0 && c == rst_cyc + 1) rst = 1'b0;
      if (c == N+3 && rst_cyc == 0) begin
        check("busy_after_done", Busy, 0);
        check("product_held", Product, p);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; St = 1'b0; Mplier = '0; Mcand = '0;
    repeat (2) @(negedge Clk);
    check("reset_load", Load, 0);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_product", Product, 0);
    rst = 1'b0;

    run_op(8'd13,  8'd11,  16'd143,   0, 0);
    run_op(8'd255, 8'd255, 16'd65025, 0, 0);
    run_op(8'd0,   8'd200, 16'd0,     0, 0);
    run_op(8'd1,   8'd1,   16'd1,     0, 0);
    run_op(8'd200, 8'd3,   16'd600,   4, 0);
    run_op(8'd50,  8'd50,  16'd2500,  0, 5);
    run_op(8'd7,   8'd9,   16'd63,    0, 0);

    // Back-to-back with St held high across both operations.
    begin
      int c0;
      @(negedge Clk);
      St = 1'b1; Mplier = 8'd3; Mcand = 8'd5;
      c0 = cyc + 1;
      exp_load_cyc_q.push_back(c0);
      exp_load_cyc_q.push_back(c0 + N + 3);
      exp_prod_q.push_back(16'd15);
      exp_done_cyc_q.push_back(c0 + N + 1);
      exp_prod_q.push_back(16'd20000);
      exp_done_cyc_q.push_back(c0 + 2*N + 4);
      @(negedge Clk);
      Mplier = 8'd200; Mcand = 8'd100;
      repeat (N+3) @(negedge Clk);
      St = 1'b0;
      repeat (N+2) @(negedge Clk);
      check("b2b_busy_after", Busy, 0);
      check("b2b_product", Product, 20000);
    end

    // Product hold with K toggling while idle.
    k_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("hold_product", Product, 20000);
      check("hold_busy", Busy, 0);
    end
    k_rand = 1'b0;
    repeat (2) @(negedge Clk);

    check("load_queue_empty", exp_load_cyc_q.size(), 0);
    check("done_queue_empty", exp_prod_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential unsigned shift-add multiplier that sits directly upstream of the multiplier iteration counter. It accepts two N-bit operands on a start strobe, pulses `Load` to start the counter, and performs one add-and-shift step per clock. When the counter returns `K`, it publishes the 2N-bit product with a one-cycle `Done` pulse. Operands and product are registered, so the block is self-contained apart from the external counter.

## Interface
- `N`, default 8: operand width in bits; product width is 2N.
- `Clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `St`  in  1: start strobe; sampled only in IDLE.
- `Mplier`  in  N: multiplier operand; latched on accepted `St`.
- `Mcand`  in  N: multiplicand operand; latched on accepted `St`.
- `K`  in  1: final-iteration flag from the counter; sampled only in RUN.
- `Load`  out  1: registered one-cycle pulse that starts the counter.
- `Busy`  out  1: registered; high in RUN and DONE.
- `Done`  out  1: registered one-cycle pulse; `Product` is valid from this cycle onward.
- `Product`  out  2N: result; holds its value until the next `Done`.

## Operation
- Internal registers:
  - `ACC`, 2N+1 bits: upper N+1 bits hold the partial sum including carry; lower N bits hold the remaining multiplier bits.
  - `MC`, N bits: the latched multiplicand.
- States are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - `St`=1: `ACC` <= {N+1 zeros, `Mplier`}, `MC` <= `Mcand`, `Load` <= 1, `Busy` <= 1, go to RUN.
  - `St`=0: stay in IDLE with all outputs held.
- RUN with `K`=0 (one step):
  - If `ACC[0]`=1: `ACC` <= ({`ACC[2N:N]` + `MC`, `ACC[N-1:0]`}) >> 1, with the add done at N+1 bits.
  - Otherwise: `ACC` <= `ACC` >> 1.
  - `Load` <= 0.
- RUN with `K`=1: no step. `Product` <= `ACC[2N-1:0]`, `Done` <= 1, go to DONE.
- DONE: `Done` <= 0, `Busy` <= 0, go to IDLE.
- `St` outside IDLE is ignored and is not queued.
- `K` outside RUN is ignored.
- The carry bit `ACC[2N]` is always 0 after a shift. There is no overflow, because N x N fits in 2N bits.
- `rst` during any state: return to IDLE immediately. `ACC`, `MC`, `Product`, `Load`, `Busy` and `Done` all go to 0. The operation in flight is discarded and no `Done` is issued.

## Timing
- Reset values: `Load`=0, `Busy`=0, `Done`=0, `Product`=0.
- Edge e0: `St` is accepted. `Load` and `Busy` are high in the cycle following e0, which is RUN cycle 1.
- A step occurs at the end of every RUN cycle in which `K`=0, including RUN cycle 1 while `Load`=1.
- The counter must return `K`=1 in RUN cycle N+1, after exactly N steps. The block does not count iterations itself.
- A correct result needs exactly N steps. Any other K timing produces an undefined `Product`, but the FSM still reaches DONE and then IDLE.
- `Done` is high in cycle N+2 after e0. `Busy` drops at the same edge that ends `Done`.
- Start-to-start minimum spacing is N+3 cycles. `St` may be held high and is re-accepted on the first IDLE cycle.
- Simultaneous `St` and `rst`: reset wins.

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_state_t` {IDLE, RUN, DONE};
  - default width constant `MULT_N` = 8.
- Optional sub-module `mult_acc_shift`: the `ACC` register plus the N+1-bit adder and right shift, with step and init controls.
- The FSM and the output registers stay in the top module.
- The iteration counter is instantiated by the parent, not inside this block.

## Test plan
- Basic multiply: `Mplier`=13, `Mcand`=11, bench K model asserts `K` in RUN cycle 9. Required: `Product`=143, `Done` exactly once in cycle 10 after `St`, `Load` high only in cycle 1.
- Extremes:
  - 255 x 255 gives `Product`=65025, exercising the carry into `ACC[2N]`.
  - 0 x 200 gives `Product`=0.
  - 1 x 1 gives `Product`=1.
- Ignored start: pulse `St` in RUN cycle 4 with different operands. Required: result unchanged, no second `Load`, and `Busy` low after the first `Done`.
- Reset mid-operation: assert `rst` in RUN cycle 5. Required: all outputs read 0 asynchronously and no `Done`. Then 7 x 9 gives 63.
- Back-to-back: hold `St` high across two operations, 3 x 5 then 200 x 100. Required: 15 then 20000, with `Load` pulses N+3 cycles apart.
- Product hold: after `Done`, wait 20 idle cycles with `K` toggling randomly. Required: `Product` stable, `Busy`=0, no `Done`.
